// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder that streams encoded words into
// instruction memory, one per cycle, from a base address.
module instr_encoder (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  count,
  output logic        full,
  output logic        err_invalid,
  output logic [4:0]  err_mnem
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FULL
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  ptr;
  logic        is_r;
  logic        is_i;
  logic        is_j;
  logic        valid_mnem;
  logic [5:0]  fn;
  logic [5:0]  op;
  logic [4:0]  rt_e;
  logic [4:0]  rd_e;
  logic [31:0] enc;
  logic        accept;
  logic        wr;
  logic        bad;
  logic        load;
  logic        last;

  always_comb begin
    is_r = 1'b0;
    is_i = 1'b0;
    is_j = 1'b0;
    fn   = 6'h00;
    op   = 6'h00;
    rt_e = rt;
    rd_e = rd;
    case (mnem)
      5'd0:  begin is_r = 1'b1; fn = 6'h04; end
      5'd1:  begin is_r = 1'b1; fn = 6'h06; end
      5'd2:  begin is_r = 1'b1; fn = 6'h07; end
      5'd3: begin
        is_r = 1'b1;
        fn   = 6'h08;
        rt_e = 5'd0;
        rd_e = 5'd0;
      end
      5'd4:  begin is_r = 1'b1; fn = 6'h20; end
      5'd5:  begin is_r = 1'b1; fn = 6'h21; end
      5'd6:  begin is_r = 1'b1; fn = 6'h22; end
      5'd7:  begin is_r = 1'b1; fn = 6'h23; end
      5'd8:  begin is_r = 1'b1; fn = 6'h24; end
      5'd9:  begin is_r = 1'b1; fn = 6'h25; end
      5'd10: begin is_r = 1'b1; fn = 6'h26; end
      5'd11: begin is_r = 1'b1; fn = 6'h27; end
      5'd12: begin is_j = 1'b1; op = 6'h02; end
      5'd13: begin is_i = 1'b1; op = 6'h04; end
      5'd14: begin is_i = 1'b1; op = 6'h05; end
      5'd15: begin
        is_i = 1'b1;
        op   = 6'h06;
        rt_e = 5'd0;
      end
      5'd16: begin
        is_i = 1'b1;
        op   = 6'h07;
        rt_e = 5'd0;
      end
      5'd17: begin is_i = 1'b1; op = 6'h08; end
      5'd18: begin is_i = 1'b1; op = 6'h09; end
      5'd19: begin is_i = 1'b1; op = 6'h0C; end
      5'd20: begin is_i = 1'b1; op = 6'h0D; end
      5'd21: begin is_i = 1'b1; op = 6'h0E; end
      5'd22: begin is_i = 1'b1; op = 6'h23; end
      5'd23: begin is_i = 1'b1; op = 6'h2B; end
      default: ;
    endcase
  end

  always_comb begin
    enc = 32'h0;
    unique case (1'b1)
      is_r:    enc = {6'h00, rs, rt_e, rd_e, 5'd0, fn};
      is_i:    enc = {op, rs, rt_e, imm};
      is_j:    enc = {op, target};
      default: enc = 32'h0;
    endcase
  end

  assign valid_mnem = is_r | is_i | is_j;
  assign in_ready   = (state == RUN);
  assign accept     = in_valid & in_ready;
  assign wr         = accept & valid_mnem;
  assign bad        = accept & ~valid_mnem;
  assign last       = (ptr == 8'hFF);
  // stop wins over start; start is only honoured outside RUN
  assign load       = start & ~stop & (state != RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load) state_nx = RUN;
      RUN: begin
        if (stop)            state_nx = IDLE;
        else if (wr && last) state_nx = FULL;
      end
      FULL: begin
        if (stop)      state_nx = IDLE;
        else if (load) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 8'h00;
      mem_we      <= 1'b0;
      mem_addr    <= 8'h00;
      mem_wdata   <= 32'h0;
      count       <= 9'd0;
      full        <= 1'b0;
      err_invalid <= 1'b0;
      err_mnem    <= 5'd0;
    end else begin
      state  <= state_nx;
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= ptr;
        mem_wdata <= enc;
        count     <= count + 9'd1;
        if (last) full <= 1'b1;
        else      ptr  <= ptr + 8'd1;
      end
      if (bad && !err_invalid) begin
        err_invalid <= 1'b1;
        err_mnem    <= mnem;
      end
      if (load) begin
        ptr         <= base;
        count       <= 9'd0;
        full        <= 1'b0;
        err_invalid <= 1'b0;
        err_mnem    <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed
// instruction words and addresses.
module tb_instr_encoder;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  base;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  mnem;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic        full;
  logic        err_invalid;
  logic [4:0]  err_mnem;

  int nvec;
  int nerr;

  instr_encoder dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .base        (base),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mnem        (mnem),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .target      (target),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .count       (count),
    .full        (full),
    .err_invalid (err_invalid),
    .err_mnem    (err_mnem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [4:0]  m,
                     input logic [4:0]  a,
                     input logic [4:0]  b,
                     input logic [4:0]  c,
                     input logic [15:0] i,
                     input logic [25:0] t);
    mnem     = m;
    rs       = a;
    rt       = b;
    rd       = c;
    imm      = i;
    target   = t;
    in_valid = 1'b1;
  endtask

  task automatic wr_chk(input string tag,
                        input logic [7:0]  a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, mem_wdata, d);
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    base     = 8'h00;
    in_valid = 1'b0;
    mnem     = 5'd0;
    rs       = 5'd0;
    rt       = 5'd0;
    rd       = 5'd0;
    imm      = 16'h0;
    target   = 26'h0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err_invalid), 32'd0);
    chk("rst_errm", 32'(err_mnem), 32'd0);

    // basic encodings
    start = 1'b1;
    base  = 8'h10;
    step();
    start = 1'b0;
    chk("run_ready", 32'(in_ready), 32'd1);
    chk("run_count", 32'(count), 32'd0);
    req(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    wr_chk("add", 8'h10, 32'h00221820);
    req(5'd17, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0);
    step();
    wr_chk("addi", 8'h11, 32'h20220005);
    req(5'd22, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
    step();
    wr_chk("lw", 8'h12, 32'h8FA80004);
    chk("count3", 32'(count), 32'd3);

    // remaining formats
    req(5'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    step();
    wr_chk("j", 8'h13, 32'h08000010);
    req(5'd23, 5'd29, 5'd8, 5'd0, 16'h0, 26'h0);
    step();
    wr_chk("sw", 8'h14, 32'hAFA80000);
    req(5'd15, 5'd4, 5'd7, 5'd0, 16'hFFFF, 26'h0);
    step();
    wr_chk("blez", 8'h15, 32'h1880FFFF);
    req(5'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    step();
    wr_chk("sllv", 8'h16, 32'h00A63804);
    req(5'd3, 5'd3, 5'd5, 5'd6, 16'h0, 26'h0);
    step();
    wr_chk("jr", 8'h17, 32'h00600008);

    // invalid mnemonic between two valid ones
    req(5'd5, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    step();
    wr_chk("addu", 8'h18, 32'h00210821);
    req(5'd27, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
    step();
    chk("inv_we", 32'(mem_we), 32'd0);
    chk("inv_err", 32'(err_invalid), 32'd1);
    chk("inv_errm", 32'(err_mnem), 32'd27);
    chk("inv_hold_addr", 32'(mem_addr), 32'h18);
    chk("inv_hold_data", mem_wdata, 32'h00210821);
    req(5'd6, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
    step();
    wr_chk("sub", 8'h19, 32'h00432022);
    req(5'd30, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    chk("inv2_we", 32'(mem_we), 32'd0);
    chk("inv2_errm", 32'(err_mnem), 32'd27);
    chk("count10", 32'(count), 32'd10);

    // request together with stop is still written
    req(5'd20, 5'd0, 5'd1, 5'd0, 16'h00FF, 26'h0);
    stop = 1'b1;
    step();
    stop     = 1'b0;
    in_valid = 1'b0;
    wr_chk("ori_stop", 8'h1A, 32'h340100FF);
    chk("stop_ready", 32'(in_ready), 32'd0);
    chk("count11", 32'(count), 32'd11);
    step();
    chk("we_pulse", 32'(mem_we), 32'd0);

    // full boundary from base 254
    start = 1'b1;
    base  = 8'hFE;
    step();
    start = 1'b0;
    chk("fb_ready", 32'(in_ready), 32'd1);
    chk("fb_errclr", 32'(err_invalid), 32'd0);
    req(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    wr_chk("fb0", 8'hFE, 32'h00221820);
    chk("fb0_ready", 32'(in_ready), 32'd1);
    req(5'd17, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0);
    step();
    wr_chk("fb1", 8'hFF, 32'h20220005);
    chk("fb_full", 32'(full), 32'd1);
    chk("fb_ready0", 32'(in_ready), 32'd0);
    req(5'd10, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    chk("fb2_we", 32'(mem_we), 32'd0);
    chk("fb_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    start    = 1'b1;
    base     = 8'h00;
    step();
    start = 1'b0;
    chk("rs_ready", 32'(in_ready), 32'd1);
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_full", 32'(full), 32'd0);

    // start inside RUN is ignored
    start = 1'b1;
    base  = 8'h40;
    req(5'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    start = 1'b0;
    wr_chk("and_ign", 8'h00, 32'h00221824);

    // base 255 allows one write
    in_valid = 1'b0;
    stop     = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    base  = 8'hFF;
    step();
    start = 1'b0;
    req(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    wr_chk("b255", 8'hFF, 32'h00221820);
    chk("b255_full", 32'(full), 32'd1);
    chk("b255_ready", 32'(in_ready), 32'd0);
    chk("b255_count", 32'(count), 32'd1);

    // reset mid-session cancels pending write
    start = 1'b1;
    base  = 8'h20;
    step();
    start = 1'b0;
    req(5'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    wr_chk("pre_rst", 8'h20, 32'h00221820);
    reset = 1'b1;
    step();
    chk("mr_we", 32'(mem_we), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    chk("mr_data", mem_wdata, 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    chk("mr_we2", 32'(mem_we), 32'd0);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    base  = 8'h05;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_ready", 32'(in_ready), 32'd0);
    step();
    chk("ss_ready2", 32'(in_ready), 32'd0);
    chk("ss_we", 32'(mem_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port `clock`: input, 1 bit, rising-edge clock.
REQ-003 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, pulse that begins a load session at `base`.
REQ-005 Port `stop`: input, 1 bit, pulse that ends the session.
REQ-006 Port `base`: input, 8 bits, first instruction-memory word address.
REQ-007 Port `in_valid`: input, 1 bit, instruction request present.
REQ-008 Port `in_ready`: output, 1 bit, block accepts a request this cycle.
REQ-009 Port `mnem`: input, 5 bits, mnemonic index (REQ-016).
REQ-010 Ports `rs`, `rt`, `rd`: input, 5 bits each, register fields.
REQ-011 Port `imm`: input, 16 bits, immediate / branch offset.
REQ-012 Port `target`: input, 26 bits, jump target field.
REQ-013 Ports `mem_we` (1 bit), `mem_addr` (8 bits), `mem_wdata` (32 bits): outputs, instruction-memory write port.
REQ-014 Ports `count` (9 bits), `full` (1 bit), `err_invalid` (1 bit), `err_mnem` (5 bits): outputs, status.

Function
REQ-015 States SHALL be IDLE, RUN and FULL; `in_ready` = 1 only in RUN.
REQ-016 Mnemonic indices SHALL be: 0 SLLV, 1 SRLV, 2 SRAV, 3 JR, 4 ADD, 5 ADDU, 6 SUB, 7 SUBU, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 J, 13 BEQ, 14 BNE, 15 BLEZ, 16 BGTZ, 17 ADDI, 18 ADDIU, 19 ANDI, 20 ORI, 21 XORI, 22 LW, 23 SW. Indices 24-31 are invalid.
REQ-017 R-type encoding SHALL be op=0, rs, rt, rd, shamt=0, fn.
- fn values: SLLV 04, SRLV 06, SRAV 07, JR 08, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27 (hex).
- JR forces rt=0 and rd=0.
REQ-018 I-type encoding SHALL be {op, rs, rt, imm}.
- op values: BEQ 04, BNE 05, BLEZ 06, BGTZ 07, ADDI 08, ADDIU 09, ANDI 0C, ORI 0D, XORI 0E, LW 23, SW 2B (hex).
- BLEZ and BGTZ force rt=0.
REQ-019 J SHALL encode as {6'h02, target}.
REQ-020 A request SHALL be accepted on a cycle with `in_valid` & `in_ready`.
REQ-021 A valid request accepted at cycle N SHALL produce `mem_we`=1 at cycle N+1, for exactly one cycle.
- `mem_addr` = write pointer at acceptance; `mem_wdata` = registered encoding.
- Throughput: one instruction per cycle.
REQ-022 The write pointer SHALL increment by 1 per accepted valid request; `count` SHALL increment by 1 in the same cycle as `mem_we`.
REQ-023 Accepting a valid request while the pointer is 255 SHALL move RUN to FULL on that edge and raise `full`.
- The word at 255 is still written at N+1.
- The pointer SHALL NOT wrap.
REQ-024 An accepted invalid mnemonic SHALL complete the handshake without a write and without advancing the pointer.
- It sets sticky `err_invalid`=1 and captures `err_mnem`, first error only.
REQ-025 `start` in IDLE or FULL SHALL load pointer=`base` and enter RUN, clearing `count`, `full`, `err_invalid` and `err_mnem`.
- `start` in RUN SHALL be ignored.
REQ-026 `stop` in RUN or FULL SHALL enter IDLE; `stop` in IDLE SHALL be ignored.
- A write already pending from cycle N SHALL still complete at N+1.
- A request presented together with `stop` SHALL be accepted, since `in_ready` was 1 that cycle.
REQ-027 `start` and `stop` asserted together SHALL be treated as `stop` only.
REQ-028 `base`=255 SHALL allow exactly one write before FULL.
REQ-029 `mem_addr` and `mem_wdata` SHALL hold their last values while `mem_we`=0.

Reset
REQ-030 On `reset`=1 at a clock edge, the state SHALL be IDLE and all outputs 0 (`in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `count`, `full`, `err_invalid`, `err_mnem`), with the pointer at 0.
REQ-031 `reset` SHALL take priority over every other input, including mid-session.
- A pending write is cancelled: no `mem_we` on the following cycle.

Verification
REQ-032 Basic encodings: `start` with `base`=0x10, then in consecutive cycles:
- ADD rs=1 rt=2 rd=3 -> `mem_wdata` 0x00221820 @0x10
- ADDI rs=1 rt=2 imm=0x0005 -> 0x20220005 @0x11
- LW rs=29 rt=8 imm=0x0004 -> 0x8FA80004 @0x12
- `count`=3 at the end.
REQ-033 Remaining formats:
- J target=0x0000010 -> 0x08000010
- SW rs=29 rt=8 imm=0 -> 0xAFA80000
- BLEZ rs=4 rt=7 imm=0xFFFF -> 0x1880FFFF (rt forced to 0)
- SLLV rs=5 rt=6 rd=7 -> 0x00A63804
REQ-034 Invalid mnemonic: `mnem`=27 between two valid requests -> no write for it, `err_invalid`=1, `err_mnem`=27, and the two valid words land at consecutive addresses.
REQ-035 Full boundary: `base`=254, three back-to-back requests -> writes at 254 and 255, `full`=1, `in_ready`=0 from the cycle after the second acceptance, third request not accepted; then `start` with `base`=0 -> RUN, `count`=0.
REQ-036 Reset and control:
- `reset` in the cycle after an accepted ADD -> no `mem_we`, all outputs 0.
- `start`+`stop` together in IDLE -> remains IDLE.
